// File: rtl/srff_bank_ctrl_pkg.sv
// Shared op codes, FSM state encodings and a width helper for the srff bank controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package srff_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SET = 2'b00,
    OP_CLR = 2'b01,
    OP_TOG = 2'b10,
    OP_RD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int cw(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/srff_bank_ctrl_if.sv
// Requester/response bundle between control logic and the srff bank controller.
// Latency: n/a. Backpressure: per-requester valid/ready, response is an unthrottled pulse.
interface srff_bank_ctrl_if #(parameter int IDXW = 3) ();
  import srff_bank_ctrl_pkg::*;

  logic            req0_valid;
  op_e             req0_op;
  logic [IDXW-1:0] req0_idx;
  logic            req0_ready;
  logic            req1_valid;
  op_e             req1_op;
  logic [IDXW-1:0] req1_idx;
  logic            req1_ready;
  logic            rsp_valid;
  logic            rsp_id;
  logic            rsp_err;
  logic            rsp_q;

  modport master (
    output req0_valid, req0_op, req0_idx, req1_valid, req1_op, req1_idx,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_q
  );

  modport slave (
    input  req0_valid, req0_op, req0_idx, req1_valid, req1_op, req1_idx,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_q
  );

endinterface

// File: rtl/srff_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves to the other requester after every grant.
// Latency: grant is combinational, pointer updates on the accepting edge.
// Backpressure: take=0 holds the pointer so a stalled grant keeps its priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (take) ptr <= gnt[0];
  end

endmodule

// File: rtl/srff_bank_ctrl.sv
// Sequences S/R pulses and the bank clock for a bank of master-slave SR cells, verifying each write.
// Latency: write PULSE_CYC+4 cycles (+PULSE_CYC+3 per retry); read / bad index 1 cycle.
// Backpressure: one request in flight; ready only while idle, at most one requester per cycle.
module srff_bank_ctrl
  import srff_bank_ctrl_pkg::*;
#(
  parameter int N         = 8,
  parameter int IDXW      = 3,
  parameter int PULSE_CYC = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst,
  srff_bank_ctrl_if.slave bus,
  output logic            busy,
  output logic [N-1:0]    ff_s,
  output logic [N-1:0]    ff_r,
  output logic            ff_clk,
  input  logic [N-1:0]    ff_q
);

  localparam int QW = 1 << IDXW;
  localparam int RW = cw(MAX_RETRY + 1);
  localparam int PW = cw(PULSE_CYC);
  localparam logic [IDXW:0] NLIM = (IDXW + 1)'(N);

  state_e          state, state_nxt;
  logic            id_r, id_nxt;
  logic            set_r, set_nxt;
  logic [IDXW-1:0] idx_r, idx_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [PW-1:0]   pcnt, pcnt_nxt;
  logic            rsp_valid_nxt, rsp_id_nxt, rsp_err_nxt, rsp_q_nxt;
  logic            drive, clk_nxt;
  logic [N-1:0]    s_nxt, r_nxt;
  logic [QW-1:0]   q_ext, sel;
  logic [1:0]      gnt;
  logic            take, gid;
  op_e             gop;
  logic [IDXW-1:0] gidx;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({bus.req1_valid, bus.req0_valid}),
    .take (take),
    .gnt  (gnt)
  );

  assign take           = (state == ST_IDLE) && !rst && (gnt != 2'b00);
  assign bus.req0_ready = take && gnt[0];
  assign bus.req1_ready = take && gnt[1];
  assign gid            = gnt[1];
  assign gop            = gid ? bus.req1_op  : bus.req0_op;
  assign gidx           = gid ? bus.req1_idx : bus.req0_idx;
  // Zero-extended so any index reads a defined bit; out-of-range cells read as 0.
  assign q_ext          = QW'(ff_q);

  always_comb begin
    state_nxt     = state;
    id_nxt        = id_r;
    set_nxt       = set_r;
    idx_nxt       = idx_r;
    retry_nxt     = retry;
    pcnt_nxt      = pcnt;
    rsp_valid_nxt = 1'b0;
    rsp_id_nxt    = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_q_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take) begin
          id_nxt    = gid;
          idx_nxt   = gidx;
          retry_nxt = '0;
          if ({1'b0, gidx} >= NLIM) begin
            rsp_valid_nxt = 1'b1;
            rsp_id_nxt    = gid;
            rsp_err_nxt   = 1'b1;
          end else if (gop == OP_RD) begin
            rsp_valid_nxt = 1'b1;
            rsp_id_nxt    = gid;
            rsp_q_nxt     = q_ext[gidx];
          end else begin
            // Toggle becomes a plain set/clear from the value seen at accept.
            set_nxt   = (gop == OP_SET) || ((gop == OP_TOG) && !q_ext[gidx]);
            state_nxt = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        state_nxt = ST_PULSE;
        pcnt_nxt  = '0;
      end
      ST_PULSE: begin
        if (int'(pcnt) == PULSE_CYC - 1) state_nxt = ST_HOLD;
        else                             pcnt_nxt  = pcnt + PW'(1);
      end
      ST_HOLD: state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (q_ext[idx_r] == set_r) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_id_nxt    = id_r;
          rsp_q_nxt     = q_ext[idx_r];
        end else if (int'(retry) < MAX_RETRY) begin
          retry_nxt = retry + RW'(1);
          state_nxt = ST_SETUP;
        end else begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_id_nxt    = id_r;
          rsp_err_nxt   = 1'b1;
          rsp_q_nxt     = q_ext[idx_r];
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they belong to.
    drive   = (state_nxt == ST_SETUP) || (state_nxt == ST_PULSE) || (state_nxt == ST_HOLD);
    clk_nxt = (state_nxt == ST_PULSE);
    sel     = QW'(1) << idx_nxt;
    s_nxt   = (drive && set_nxt)  ? sel[N-1:0] : '0;
    r_nxt   = (drive && !set_nxt) ? sel[N-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      id_r          <= 1'b0;
      set_r         <= 1'b0;
      idx_r         <= '0;
      retry         <= '0;
      pcnt          <= '0;
      busy          <= 1'b0;
      ff_s          <= '0;
      ff_r          <= '0;
      ff_clk        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      id_r          <= id_nxt;
      set_r         <= set_nxt;
      idx_r         <= idx_nxt;
      retry         <= retry_nxt;
      pcnt          <= pcnt_nxt;
      busy          <= (state_nxt != ST_IDLE);
      ff_s          <= s_nxt;
      ff_r          <= r_nxt;
      ff_clk        <= clk_nxt;
      bus.rsp_valid <= rsp_valid_nxt;
      bus.rsp_id    <= rsp_id_nxt;
      bus.rsp_err   <= rsp_err_nxt;
      bus.rsp_q     <= rsp_q_nxt;
    end
  end

endmodule

// File: tb/tb_srff_bank_ctrl.sv
// Directed bench for srff_bank_ctrl with a behavioural master-slave SR cell bank and a response scoreboard.
module tb_srff_bank_ctrl;
  import srff_bank_ctrl_pkg::*;

  localparam int N    = 8;
  localparam int IDXW = 4;
  localparam int PC   = 2;
  localparam int MR   = 2;
  localparam int LATW = PC + 4;
  localparam int LATR = PC + 3;

  typedef struct {
    bit id;
    bit err;
    bit q;
    int cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         busy;
  logic [N-1:0] ff_s, ff_r, ff_q;
  logic         ff_clk;
  logic [N-1:0] cell_m = '0;
  logic [N-1:0] cell_q = '0;
  logic [N-1:0] stuck0 = '0;
  logic [N-1:0] model = '0;
  logic [N-1:0] prev_sr = '0;
  logic         prev_clk = 1'b0;
  logic         mon_on = 1'b0;
  logic         rr_exp = 1'b0;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  exp_t         sb[$];

  srff_bank_ctrl_if #(.IDXW(IDXW)) bus ();

  srff_bank_ctrl #(.N(N), .IDXW(IDXW), .PULSE_CYC(PC), .MAX_RETRY(MR)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .ff_s   (ff_s),
    .ff_r   (ff_r),
    .ff_clk (ff_clk),
    .ff_q   (ff_q)
  );

  always #5 clk = ~clk;

  // Master latch follows S/R while ff_clk is high; slave copies it on the falling edge.
  always @(ff_clk or ff_s or ff_r) if (ff_clk) cell_m = (cell_m | ff_s) & ~ff_r;
  always @(negedge ff_clk) cell_q <= cell_m;
  assign ff_q = cell_q & ~stuck0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rsp_valid === 1'b1) begin
      chk("rsp_unexpected", (sb.size() == 0), 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_q", bus.rsp_q, e.q);
      end
    end
  endtask

  task automatic issue(input bit r, input op_e op, input logic [IDXW-1:0] idx,
                       input bit eerr, input bit eq, input int lat);
    bit ok = 0;
    exp_t e;
    if (r) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_idx = idx;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_idx = idx;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((r ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        e.id = r; e.err = eerr; e.q = eq; e.cyc = cyc + lat;
        sb.push_back(e);
        ok = 1;
        rr_exp = ~r;
      end
      tick();
      if (ok) break;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("accepted", ok, 1);
  endtask

  // Called at cycle 1 after accept; walks every attempt and ends on the response cycle.
  task automatic check_write_seq(input int idx, input bit set, input int nseq);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    for (int a = 0; a < nseq; a++) begin
      for (int k = 1; k <= PC + 3; k++) begin
        chk("ff_s_seq", ff_s, (set && k <= PC + 2) ? oh : '0);
        chk("ff_r_seq", ff_r, (!set && k <= PC + 2) ? oh : '0);
        chk("ff_clk_seq", ff_clk, (k >= 2 && k <= PC + 1));
        chk("busy_seq", busy, 1);
        tick();
      end
    end
    chk("rsp_seen", bus.rsp_valid, 1);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("s_and_r", ff_s & ff_r, 0);
      chk("sr_onehot", $onehot0(ff_s | ff_r), 1);
      if (ff_clk) chk("clk_only_busy", busy, 1);
      if (ff_clk && prev_clk) chk("sr_stable", ff_s | ff_r, prev_sr);
    end
    prev_clk = ff_clk;
    prev_sr  = ff_s | ff_r;
  end

  initial begin
    bus.req0_valid = 1'b1; bus.req0_op = OP_SET; bus.req0_idx = '0;
    bus.req1_valid = 1'b0; bus.req1_op = OP_SET; bus.req1_idx = '0;

    // reset state, with a request pending that must not be accepted
    tick(); tick();
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ff_s", ff_s, 0);
    chk("rst_ff_r", ff_r, 0);
    chk("rst_ff_clk", ff_clk, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    // SET cell 3 from requester 0
    issue(0, OP_SET, 3, 0, 1, LATW);
    check_write_seq(3, 1, 1);
    model[3] = 1'b1;
    chk("idle_after_set", busy, 0);

    // set cell 5, then toggle it twice from requester 1
    issue(0, OP_SET, 5, 0, 1, LATW);
    check_write_seq(5, 1, 1);
    model[5] = 1'b1;
    issue(1, OP_TOG, 5, 0, !model[5], LATW);
    check_write_seq(5, !model[5], 1);
    model[5] = ~model[5];
    issue(1, OP_TOG, 5, 0, !model[5], LATW);
    check_write_seq(5, !model[5], 1);
    model[5] = ~model[5];

    // both requesters valid: grants alternate, one ready per cycle
    bus.req0_valid = 1'b1; bus.req0_op = OP_RD; bus.req0_idx = 3;
    bus.req1_valid = 1'b1; bus.req1_op = OP_RD; bus.req1_idx = 7;
    for (int g = 0; g < 4; g++) begin
      exp_t e;
      #1;
      chk("ready_count", 32'(bus.req0_ready) + 32'(bus.req1_ready), 1);
      chk("grant_order", bus.req1_ready, rr_exp);
      e.id = rr_exp; e.err = 0; e.q = rr_exp ? model[7] : model[3]; e.cyc = cyc + 1;
      sb.push_back(e);
      rr_exp = ~rr_exp;
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();

    // stuck-at-0 readback on cell 2: every retry used, then error
    stuck0 = N'(1) << 2;
    issue(0, OP_SET, 2, 1, 0, LATW + MR * LATR);
    check_write_seq(2, 1, MR + 1);
    stuck0 = '0;
    model[2] = 1'b1;
    tick();

    // READ is one cycle with no bank activity; out-of-range index errors with q=0
    issue(1, OP_RD, 7, 0, model[7], 1);
    chk("rd7_rsp", bus.rsp_valid, 1);
    chk("rd7_ff_clk", ff_clk, 0);
    chk("rd7_sr", ff_s | ff_r, 0);
    chk("rd7_busy", busy, 0);
    issue(0, OP_RD, 3, 0, model[3], 1);
    chk("rd3_rsp", bus.rsp_valid, 1);
    issue(1, OP_SET, 9, 1, 0, 1);
    chk("oor_rsp", bus.rsp_valid, 1);
    chk("oor_sr", ff_s | ff_r, 0);
    chk("oor_ff_clk", ff_clk, 0);
    chk("oor_busy", busy, 0);
    tick();

    // reset in the middle of a pulse aborts with no response
    issue(0, OP_SET, 6, 0, 1, LATW);
    tick();
    chk("pre_abort_clk", ff_clk, 1);
    rst = 1'b1;
    void'(sb.pop_back());
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_ff_s", ff_s, 0);
    chk("abort_ff_r", ff_r, 0);
    chk("abort_ff_clk", ff_clk, 0);
    chk("abort_rsp", bus.rsp_valid, 0);
    rst = 1'b0;
    rr_exp = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // controller recovers after the abort
    issue(1, OP_RD, 3, 0, model[3], 1);
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
